axi_wr_responder: RTL and testbench

AXI3-style write-channel responder (subordinate) for the HBM benchmark path: the counterpart of the write-benchmark initiator. It accepts AW bursts into a FIFO and consumes W beats against the head burst. It returns one B response per burst after a programmable latency, and keeps beat/burst/response counters. It stands in for an HBM pseudo-channel in simulation and loopback self-test, so initiator throughput and latency counters can be checked against a deterministic memory.

---
 rtl/axi_wr_responder.sv | 193 +++++++++++++++++++
 tb/tb_axi_wr_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_responder.sv
// axi_wr_responder: AXI3-style write subordinate for HBM benchmark loopback.
// Queues AW, sinks W against the head burst, returns delayed B responses.
module axi_wr_responder #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int B_LATENCY  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axi_AWVALID,
  output logic                    s_axi_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
  input  logic [ID_WIDTH-1:0]     s_axi_AWID,
  input  logic [3:0]              s_axi_AWLEN,
  input  logic [2:0]              s_axi_AWSIZE,
  input  logic [1:0]              s_axi_AWBURST,
  input  logic                    s_axi_WVALID,
  output logic                    s_axi_WREADY,
  input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
  input  logic                    s_axi_WLAST,
  output logic                    s_axi_BVALID,
  input  logic                    s_axi_BREADY,
  output logic [ID_WIDTH-1:0]     s_axi_BID,
  output logic [1:0]              s_axi_BRESP,
  input  logic                    clear,
  output logic [63:0]             beats_accepted,
  output logic [63:0]             bursts_done,
  output logic [63:0]             resps_sent,
  output logic                    err_wlast
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PONE  = PW'(1);
  localparam logic [7:0]    LAT   = 8'(B_LATENCY);
  localparam logic [1:0]    OKAY  = 2'b00;
  localparam logic [1:0]    SLVERR = 2'b10;

  logic                  init_q;
  logic [ID_WIDTH-1:0]   aw_id_q [FIFO_DEPTH];
  logic [3:0]            aw_len_q [FIFO_DEPTH];
  logic [PW-1:0]         aw_wp_q, aw_rp_q;
  logic [PW:0]           aw_cnt_q, aw_cnt_d;
  logic [ADDR_WIDTH-1:0] dbg_awaddr_q;
  logic [ID_WIDTH-1:0]   b_id_q [FIFO_DEPTH];
  logic [1:0]            b_resp_q [FIFO_DEPTH];
  logic [PW-1:0]         b_wp_q, b_rp_q;
  logic [PW:0]           b_cnt_q, b_cnt_d;
  logic [7:0]            cd_q, cd_d;
  logic [3:0]            beat_q;
  logic                  berr_q;
  logic [63:0]           beats_q, bursts_q, resps_q;
  logic                  err_q;

  logic aw_full, aw_empty, b_full, b_empty;
  logic aw_push, w_hs, w_final, w_bad;
  logic b_push, b_pop, bvalid;
  logic [1:0] resp_new;
  logic unused_sink;

  assign aw_full  = aw_cnt_q == DEPTH;
  assign aw_empty = aw_cnt_q == '0;
  assign b_full   = b_cnt_q == DEPTH;
  assign b_empty  = b_cnt_q == '0;

  assign s_axi_AWREADY = init_q && !aw_full;
  assign aw_push = s_axi_AWVALID && s_axi_AWREADY;

  assign s_axi_WREADY = !aw_empty && !b_full;
  assign w_hs    = s_axi_WVALID && s_axi_WREADY;
  assign w_final = beat_q == aw_len_q[aw_rp_q];
  assign w_bad   = s_axi_WLAST != w_final;
  assign b_push  = w_hs && w_final;
  assign resp_new = (berr_q || w_bad) ? SLVERR : OKAY;

  assign bvalid = !b_empty && cd_q == 8'd0;
  assign b_pop  = bvalid && s_axi_BREADY;
  assign s_axi_BVALID = bvalid;
  assign s_axi_BID   = b_empty ? '0 : b_id_q[b_rp_q];
  assign s_axi_BRESP = b_empty ? OKAY : b_resp_q[b_rp_q];

  assign beats_accepted = beats_q;
  assign bursts_done    = bursts_q;
  assign resps_sent     = resps_q;
  assign err_wlast      = err_q;

  assign unused_sink = ^{dbg_awaddr_q, s_axi_AWSIZE, s_axi_AWBURST,
                         s_axi_WDATA, s_axi_WSTRB};

  // Occupancy next-state and head countdown reload on new head
  always_comb begin
    aw_cnt_d = aw_cnt_q;
    b_cnt_d  = b_cnt_q;
    cd_d     = cd_q;
    if (aw_push) aw_cnt_d = aw_cnt_d + CONE;
    if (b_push)  aw_cnt_d = aw_cnt_d - CONE;
    if (b_push)  b_cnt_d  = b_cnt_d + CONE;
    if (b_pop)   b_cnt_d  = b_cnt_d - CONE;
    if (b_push && (b_empty || (b_pop && b_cnt_q == CONE)))
      cd_d = LAT;
    else if (b_pop && b_cnt_q != CONE)
      cd_d = LAT;
    else if (cd_q != 8'd0)
      cd_d = cd_q - 8'd1;
  end

  // AWREADY is held low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  // AW FIFO of {ID, LEN}; popped by the final W beat of the head burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        aw_id_q[i]  <= '0;
        aw_len_q[i] <= '0;
      end
      aw_wp_q      <= '0;
      aw_rp_q      <= '0;
      aw_cnt_q     <= '0;
      dbg_awaddr_q <= '0;
    end else begin
      if (aw_push) begin
        aw_id_q[aw_wp_q]  <= s_axi_AWID;
        aw_len_q[aw_wp_q] <= s_axi_AWLEN;
        aw_wp_q           <= aw_wp_q + PONE;
        dbg_awaddr_q      <= s_axi_AWADDR;
      end
      if (b_push) aw_rp_q <= aw_rp_q + PONE;
      aw_cnt_q <= aw_cnt_d;
    end
  end

  // Beat position and per-burst WLAST error mark for the head burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      berr_q <= 1'b0;
    end else if (w_hs) begin
      beat_q <= w_final ? 4'd0 : beat_q + 4'd1;
      berr_q <= w_final ? 1'b0 : (berr_q | w_bad);
    end
  end

  // B FIFO of {ID, RESP} with the head latency countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        b_id_q[i]   <= '0;
        b_resp_q[i] <= '0;
      end
      b_wp_q  <= '0;
      b_rp_q  <= '0;
      b_cnt_q <= '0;
      cd_q    <= '0;
    end else begin
      if (b_push) begin
        b_id_q[b_wp_q]   <= aw_id_q[aw_rp_q];
        b_resp_q[b_wp_q] <= resp_new;
        b_wp_q           <= b_wp_q + PONE;
      end
      if (b_pop) b_rp_q <= b_rp_q + PONE;
      b_cnt_q <= b_cnt_d;
      cd_q    <= cd_d;
    end
  end

  // Statistics counters and sticky error; clear wins over increments
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      bursts_q <= '0;
      resps_q  <= '0;
      err_q    <= 1'b0;
    end else if (clear) begin
      beats_q  <= '0;
      bursts_q <= '0;
      resps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (w_hs)          beats_q  <= beats_q + 64'd1;
      if (b_push)        bursts_q <= bursts_q + 64'd1;
      if (b_pop)         resps_q  <= resps_q + 64'd1;
      if (w_hs && w_bad) err_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wr_responder.sv
// tb_axi_wr_responder: directed stimulus with a B-channel scoreboard.
// Expected responses are queued at W issue and checked by a monitor.
module tb_axi_wr_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [32:0]  awaddr = '0;
  logic [4:0]   awid = '0;
  logic [3:0]   awlen = '0;
  logic [2:0]   awsize = 3'd5;
  logic [1:0]   awburst = 2'd1;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '1;
  logic         wlast = 1'b0;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [4:0]   bid;
  logic [1:0]   bresp;
  logic         clear = 1'b0;
  logic [63:0]  beats, bursts, resps;
  logic         err;

  typedef struct {
    logic [4:0] id;
    logic [1:0] resp;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_w_edge = 0;
  int   first_w_edge = 0;
  int   w_stalls = 0;
  exp_t mon_e;
  logic hold_v = 1'b0;
  logic [4:0] hold_id = '0;
  logic [1:0] hold_resp = '0;

  axi_wr_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axi_AWVALID  (awvalid),
    .s_axi_AWREADY  (awready),
    .s_axi_AWADDR   (awaddr),
    .s_axi_AWID     (awid),
    .s_axi_AWLEN    (awlen),
    .s_axi_AWSIZE   (awsize),
    .s_axi_AWBURST  (awburst),
    .s_axi_WVALID   (wvalid),
    .s_axi_WREADY   (wready),
    .s_axi_WDATA    (wdata),
    .s_axi_WSTRB    (wstrb),
    .s_axi_WLAST    (wlast),
    .s_axi_BVALID   (bvalid),
    .s_axi_BREADY   (bready),
    .s_axi_BID      (bid),
    .s_axi_BRESP    (bresp),
    .clear          (clear),
    .beats_accepted (beats),
    .bursts_done    (bursts),
    .resps_sent     (resps),
    .err_wlast      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // B monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected: got bid %0d expected none", bid);
        end else begin
          mon_e = sb.pop_front();
          chk("bid", {59'd0, bid}, {59'd0, mon_e.id});
          chk("bresp", {62'd0, bresp}, {62'd0, mon_e.resp});
        end
        hs_cyc.push_back(cyc);
      end
      if (bvalid && !bready && hold_v) begin
        chk("bid_stable", {59'd0, bid}, {59'd0, hold_id});
        chk("bresp_stable", {62'd0, bresp}, {62'd0, hold_resp});
      end
      hold_v    = bvalid && !bready;
      hold_id   = bid;
      hold_resp = bresp;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send_aw(input logic [4:0] id, input logic [3:0] len);
    int n = 0;
    awvalid = 1'b1;
    awid    = id;
    awlen   = len;
    awaddr  = {28'd0, id};
    @(negedge clk);
    while (!awready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!awready) begin
      checks++;
      failures++;
      $display("FAIL aw_timeout: got awready 0 expected 1");
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
  endtask

  // track: 0 none, 1 stalls after beat 0, 2 all stalls
  task automatic send_w(input logic [4:0] id, input logic [3:0] len,
                        input int bad, input int track);
    exp_t e;
    e.id   = id;
    e.resp = (bad >= 0) ? 2'b10 : 2'b00;
    sb.push_back(e);
    for (int b = 0; b <= int'(len); b++) begin
      int n = 0;
      wvalid = 1'b1;
      wdata  = {8{$urandom()}};
      wlast  = (bad >= 0) ? (b == bad) : (b == int'(len));
      @(negedge clk);
      while (!wready && n < 500) begin
        if (track == 2 || (track == 1 && b > 0)) w_stalls++;
        @(negedge clk);
        n++;
      end
      if (!wready) begin
        checks++;
        failures++;
        $display("FAIL w_timeout: got wready 0 expected 1");
      end
      if (b == 0) first_w_edge = cyc + 1;
      last_w_edge = cyc + 1;
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_beats", beats, 64'd0);
    chk("clr_bursts", bursts, 64'd0);
    chk("clr_resps", resps, 64'd0);
    chk("clr_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("init_awready", {63'd0, awready}, 64'd1);
    chk("init_wready", {63'd0, wready}, 64'd0);
    chk("init_bvalid", {63'd0, bvalid}, 64'd0);
    chk("init_bid", {59'd0, bid}, 64'd0);
    chk("init_bresp", {62'd0, bresp}, 64'd0);
    chk("init_beats", beats, 64'd0);
    chk("init_bursts", bursts, 64'd0);
    chk("init_resps", resps, 64'd0);
    chk("init_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;

    // single burst, latency
    send_aw(5'd5, 4'd3);
    send_w(5'd5, 4'd3, -1, 0);
    chk("beat_span", 64'(last_w_edge - first_w_edge), 64'd3);
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", 64'(cyc - last_w_edge), 64'd4);
    wait_drain(50);
    chk("s_beats", beats, 64'd4);
    chk("s_bursts", bursts, 64'd1);
    chk("s_resps", resps, 64'd1);

    // AW back-pressure
    for (int i = 0; i < 8; i++) send_aw(5'(i), 4'd0);
    awvalid = 1'b1;
    awid    = 5'd8;
    awlen   = 4'd0;
    repeat (3) @(negedge clk);
    chk("awready_full", {63'd0, awready}, 64'd0);
    @(posedge clk);
    #1;
    wvalid = 1'b1;
    wlast  = 1'b1;
    mon_e.id   = 5'd0;
    mon_e.resp = 2'b00;
    sb.push_back(mon_e);
    @(negedge clk);
    chk("wready_bp", {63'd0, wready}, 64'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
    @(negedge clk);
    chk("awready_after_pop", {63'd0, awready}, 64'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    for (int i = 1; i < 9; i++) send_w(5'(i), 4'd0, -1, 0);
    wait_drain(100);
    chk("bp_beats", beats, 64'd13);
    chk("bp_bursts", bursts, 64'd10);
    chk("bp_resps", resps, 64'd10);

    // WLAST error
    send_aw(5'd3, 4'd3);
    send_w(5'd3, 4'd3, 1, 0);
    wait_drain(50);
    chk("err_set", {63'd0, err}, 64'd1);
    send_aw(5'd4, 4'd1);
    send_w(5'd4, 4'd1, -1, 0);
    wait_drain(50);
    chk("err_sticky", {63'd0, err}, 64'd1);
    pulse_clear();

    // B stall
    bready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_aw(5'(10 + i), 4'd0);
      send_w(5'(10 + i), 4'd0, -1, 0);
    end
    send_aw(5'd18, 4'd0);
    hs_cyc.delete();
    fork
      send_w(5'd18, 4'd0, -1, 0);
      begin
        @(negedge clk);
        chk("wready_bfull", {63'd0, wready}, 64'd0);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        bready = 1'b1;
      end
    join
    wait_drain(200);
    chk("stall_hs_cnt", 64'(hs_cyc.size()), 64'd9);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("stall_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd5);
    pulse_clear();

    // streaming
    hs_cyc.delete();
    w_stalls = 0;
    fork
      for (int k = 0; k < 16; k++) send_aw(5'(k), 4'd15);
      for (int k = 0; k < 16; k++)
        send_w(5'(k), 4'd15, -1, (k == 0) ? 1 : 2);
    join
    wait_drain(100);
    chk("stream_stalls", 64'(w_stalls), 64'd0);
    chk("stream_hs_cnt", 64'(hs_cyc.size()), 64'd16);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("stream_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd16);
    chk("st_beats", beats, 64'd256);
    chk("st_bursts", bursts, 64'd16);
    chk("st_resps", resps, 64'd16);

    // reset mid-burst
    send_aw(5'd20, 4'd3);
    wvalid = 1'b1;
    wlast  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("mr_awready", {63'd0, awready}, 64'd0);
    chk("mr_wready", {63'd0, wready}, 64'd0);
    chk("mr_bvalid", {63'd0, bvalid}, 64'd0);
    chk("mr_beats", beats, 64'd0);
    chk("mr_bursts", bursts, 64'd0);
    chk("mr_resps", resps, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bvalid) seen++;
    end
    chk("mr_no_b", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send_aw(5'd21, 4'd1);
    send_w(5'd21, 4'd1, -1, 0);
    wait_drain(50);
    chk("mr_new_beats", beats, 64'd2);
    chk("mr_new_bursts", bursts, 64'd1);
    chk("mr_new_resps", resps, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
